// File: rtl/can_pkg.sv
// Shared types and constants for the CAN RX frame packer: FSM states, captured frame record, length helpers.
// Combinational helpers only; no latency or backpressure of their own.
package can_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int CAN_MAX_DATA    = 8;
  localparam int FIFO_SLOT_BYTES = 16;
  localparam int INFO_FF_BIT     = 7;
  localparam int INFO_RTR_BIT    = 6;

  typedef struct packed {
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [28:0] id;
    logic [63:0] data;
  } frame_t;

  // Remote frames carry no payload; DLC 9..15 still means 8 bytes on the wire.
  function automatic logic [3:0] data_bytes(input logic rtr, input logic [3:0] dlc);
    if (rtr) return 4'd0;
    return (dlc > 4'(CAN_MAX_DATA)) ? 4'(CAN_MAX_DATA) : dlc;
  endfunction

  function automatic logic [3:0] frame_len(input logic ide, input logic rtr, input logic [3:0] dlc);
    return 4'd1 + (ide ? 4'd4 : 4'd2) + data_bytes(rtr, dlc);
  endfunction

endpackage

// File: rtl/can_rx_byte_mux.sv
// SJA1000 RX-buffer byte map: selects byte idx (info, ID bytes, then data bytes) of a captured frame.
// Purely combinational, zero latency, no backpressure.
module can_rx_byte_mux
  import can_pkg::*;
(
  input  frame_t     f,
  input  logic [3:0] idx,
  output logic [7:0] byte_out
);

  logic [3:0]  hdr_len;
  logic [2:0]  didx;
  logic [63:0] shifted;
  logic [7:0]  info;

  always_comb begin
    info               = 8'h00;
    info[INFO_FF_BIT]  = f.ide;
    info[INFO_RTR_BIT] = f.rtr;
    info[3:0]          = f.dlc;
    hdr_len            = f.ide ? 4'd5 : 4'd3;
    didx               = 3'(idx - hdr_len);
    // data[63:56] is payload byte 0, so shift the wanted byte to the top
    shifted            = f.data << {didx, 3'b000};
    byte_out           = 8'h00;
    if (idx == 4'd0) begin
      byte_out = info;
    end else if (idx >= hdr_len) begin
      byte_out = shifted[63:56];
    end else if (f.ide) begin
      case (idx[2:0])
        3'd1:    byte_out = f.id[28:21];
        3'd2:    byte_out = f.id[20:13];
        3'd3:    byte_out = f.id[12:5];
        default: byte_out = {f.id[4:0], f.rtr, 2'b00};
      endcase
    end else begin
      byte_out = (idx == 4'd1) ? f.id[10:3] : {f.id[2:0], f.rtr, 4'b0000};
    end
  end

endmodule

// File: rtl/can_rx_frame_packer.sv
// Serialises one accepted CAN frame into a contiguous FIFO wr burst (first byte 1 cycle after accept), then GAP_CYCLES idle.
// No backpressure from the FIFO; frame_ready low while busy or in reset_mode. CAN_RX_PACK_DROP_CNT_EN adds drop_cnt.
module can_rx_frame_packer
  import can_pkg::*;
#(
  parameter int GAP_CYCLES = 1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        reset_mode,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic        ide,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [28:0] id,
  input  logic [63:0] data,
  input  logic        fifo_full,
  output logic        wr,
  output logic [7:0]  data_out,
  output logic        busy
`ifdef CAN_RX_PACK_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_SLOT_BYTES);

  state_t           state, state_nxt;
  frame_t           in_f, cap, mux_f;
  logic [CNT_W-1:0] cnt, len_q, mux_idx;
  logic [2:0]       gap_cnt;
  logic             accept, last_byte, gap_done;
  logic [7:0]       mux_byte;

  assign in_f        = {ide, rtr, dlc, id, data};
  assign frame_ready = (state == ST_IDLE) & ~reset_mode;
  assign accept      = frame_valid & frame_ready;
  assign busy        = (state != ST_IDLE);
  assign last_byte   = (cnt == len_q - CNT_W'(1));
  assign gap_done    = (gap_cnt == 3'(GAP_CYCLES - 1));

  // In IDLE the mux looks at the live inputs so byte 0 can be registered on the accept edge.
  assign mux_f   = (state == ST_IDLE) ? in_f : cap;
  assign mux_idx = (state == ST_IDLE) ? '0 : cnt + CNT_W'(1);

  can_rx_byte_mux u_byte_mux (
    .f        (mux_f),
    .idx      (mux_idx),
    .byte_out (mux_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_SEND;
      ST_SEND: if (last_byte) state_nxt = ST_GAP;
      ST_GAP:  if (gap_done)  state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
    if (reset_mode) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr       <= 1'b0;
      data_out <= 8'h00;
      cap      <= '0;
      len_q    <= '0;
      cnt      <= '0;
      gap_cnt  <= '0;
    end else if (reset_mode) begin
      wr       <= 1'b0;
      data_out <= 8'h00;
      cap      <= '0;
      len_q    <= '0;
      cnt      <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          cap      <= in_f;
          len_q    <= frame_len(ide, rtr, dlc);
          cnt      <= '0;
          wr       <= 1'b1;
          data_out <= mux_byte;
        end
        ST_SEND: if (last_byte) begin
          wr      <= 1'b0;
          cnt     <= '0;
          gap_cnt <= '0;
        end else begin
          cnt      <= cnt + CNT_W'(1);
          data_out <= mux_byte;
        end
        ST_GAP:  gap_cnt <= gap_done ? 3'd0 : gap_cnt + 3'd1;
        default: wr <= 1'b0;
      endcase
    end
  end

`ifdef CAN_RX_PACK_DROP_CNT_EN
  // The FIFO will drop this packet; count it here so software can see overrun pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       drop_cnt <= 8'h00;
    else if (reset_mode)                           drop_cnt <= 8'h00;
    else if (accept && fifo_full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
  end
`else
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
`endif

endmodule
